// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite definitions for the DMAC memory responder and its bench.
package dmac_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ERR1 = 2'b10,
        S_ERR2 = 2'b11
    } slave_state_t;

endpackage

// File: rtl/dmac_sram_array.sv
// DEPTH x 32 storage: one synchronous write port, one asynchronous read port
// sharing the same word index. Contents are deliberately not reset.
module dmac_sram_array #(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Commit a write at the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmac_ahb_mem_slave.sv
// AHB-Lite responder memory used as source/destination for DMAC channels.
// Adds programmable wait states before OKAY and a two-cycle ERROR response
// for unaligned or out-of-range addresses.
//
// Handshake: an address phase is taken when HSel, HTrans is NONSEQ/SEQ and
// HReady are all high at a rising edge while the slave can accept (S_IDLE or
// S_ERR2). The data phase completes in the first cycle with HReadyOut=1
// afterwards; write data is sampled and read data is valid only in that cycle.
module dmac_ahb_mem_slave
    import dmac_ahb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         HSel,
    input  logic [31:0]  HAddr,
    input  logic [1:0]   HTrans,
    input  logic         HWrite,
    input  logic [31:0]  HWData,
    input  logic         HReady,
    output logic [31:0]  HRData,
    output logic         HReadyOut,
    output logic [1:0]   HResp,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count,
    output slave_state_t state
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

    slave_state_t     state_d;
    logic [3:0]       wait_cnt, wait_cnt_d;
    logic             cmpl_q, cmpl_d;     // current cycle is an OKAY completion
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    assign accept = HSel && HReady &&
                    ((HTrans == NONSEQ) || (HTrans == SEQ)) &&
                    ((state == S_IDLE) || (state == S_ERR2));

    // Anything above the array, or not word aligned, is answered with ERROR.
    assign addr_err = (HAddr[1:0] != 2'b00) || (HAddr[31:IDX_W+2] != '0);

    // FSM state and latched address-phase information.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            cmpl_q   <= 1'b0;
            idx_q    <= '0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            cmpl_q   <= cmpl_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
        end
    end

    // Next-state: a new accept overrides whatever the current phase would do.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        cmpl_d     = 1'b0;
        idx_d      = idx_q;
        write_d    = write_q;
        if (accept) begin
            idx_d   = HAddr[IDX_W+1:2];
            write_d = HWrite;
            if (addr_err) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d    = S_WAIT;
                wait_cnt_d = WAIT_INIT;
            end else begin
                state_d = S_IDLE;
                cmpl_d  = 1'b1;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state_d = S_IDLE;
                        cmpl_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt - 4'd1;
                    end
                end
                S_ERR1:  state_d = S_ERR2;
                S_ERR2:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign HReadyOut = (state == S_IDLE) || (state == S_ERR2);
    assign HResp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign mem_we    = cmpl_q && write_q;
    assign HRData    = (cmpl_q && !write_q) ? mem_rdata : 32'h0;

    // Statistics: count OKAY completions at the edge that ends them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (cmpl_q) begin
            if (write_q) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

    dmac_sram_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx_q),
        .wdata (HWData),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmac_ahb_mem_slave.sv
// Directed bench: one responder with no wait states, one with three.
module tb_dmac_ahb_mem_slave;
    import dmac_ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Instance with WAIT_STATES=0
    logic         h0_sel, h0_write, h0_rdy;
    logic [31:0]  h0_addr, h0_wdata, h0_rdata;
    logic [1:0]   h0_trans, h0_resp;
    logic [15:0]  h0_rdc, h0_wrc;
    slave_state_t h0_state;

    // Instance with WAIT_STATES=3
    logic         h3_sel, h3_write, h3_rdy;
    logic [31:0]  h3_addr, h3_wdata, h3_rdata;
    logic [1:0]   h3_trans, h3_resp;
    logic [15:0]  h3_rdc, h3_wrc;
    slave_state_t h3_state;

    logic [31:0] burst_d [4];

    always #5 clk = ~clk;

    dmac_ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .HSel(h0_sel), .HAddr(h0_addr), .HTrans(h0_trans),
        .HWrite(h0_write), .HWData(h0_wdata), .HReady(h0_rdy), .HRData(h0_rdata),
        .HReadyOut(h0_rdy), .HResp(h0_resp), .rd_count(h0_rdc), .wr_count(h0_wrc),
        .state(h0_state)
    );

    dmac_ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .HSel(h3_sel), .HAddr(h3_addr), .HTrans(h3_trans),
        .HWrite(h3_write), .HWData(h3_wdata), .HReady(h3_rdy), .HRData(h3_rdata),
        .HReadyOut(h3_rdy), .HResp(h3_resp), .rd_count(h3_rdc), .wr_count(h3_wrc),
        .state(h3_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] wd);
        h0_sel = (tr != 2'b00); h0_trans = tr; h0_addr = a; h0_write = w; h0_wdata = wd;
    endtask

    task automatic bus3(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] wd);
        h3_sel = (tr != 2'b00); h3_trans = tr; h3_addr = a; h3_write = w; h3_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0(2'b00, 32'h0, 1'b0, 32'h0);
        bus3(2'b00, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", h0_rdy); end
        checks++; if (h0_resp !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b expected 00", h0_resp); end
        checks++; if (h0_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", h0_rdata); end
        checks++; if (h0_rdc !== 16'd0 || h0_wrc !== 16'd0) begin errors++; $display("FAIL reset_counts: got rd=%0d wr=%0d expected 0/0", h0_rdc, h0_wrc); end
        checks++; if (h0_state !== S_IDLE || h3_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d/%0d expected 0/0", h0_state, h3_state); end
        checks++; if (h3_rdy !== 1'b1 || h3_rdc !== 16'd0) begin errors++; $display("FAIL reset_dut3: got rdy=%b rd=%0d expected 1/0", h3_rdy, h3_rdc); end
        step();
    endtask

    task automatic test_back_to_back();
        bus0(NONSEQ, 32'h10, 1'b1, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1) begin errors++; $display("FAIL b2b_addr_ready: got %b expected 1", h0_rdy); end
        step();
        bus0(NONSEQ, 32'h10, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1 || h0_rdata !== 32'h0) begin errors++; $display("FAIL b2b_write_cmpl: got rdy=%b rdata=%h expected 1/0", h0_rdy, h0_rdata); end
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h expected deadbeef", h0_rdata); end
        checks++; if (h0_rdy !== 1'b1 || h0_resp !== 2'b00) begin errors++; $display("FAIL b2b_read_cmpl: got rdy=%b resp=%b expected 1/00", h0_rdy, h0_resp); end
        step();
        @(negedge clk);
        checks++; if (h0_wrc !== 16'd1 || h0_rdc !== 16'd1) begin errors++; $display("FAIL b2b_counts: got rd=%0d wr=%0d expected 1/1", h0_rdc, h0_wrc); end
        checks++; if (h0_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata_idle: got %h expected 0", h0_rdata); end
        step();
    endtask

    task automatic test_err_range();
        bus0(NONSEQ, 32'h0, 1'b1, 32'h0);
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'h12345678);
        step();
        bus0(NONSEQ, 32'h400, 1'b1, 32'h0);
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'hFFFFFFFF);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b0 || h0_resp !== 2'b01) begin errors++; $display("FAIL oob_err1: got rdy=%b resp=%b expected 0/01", h0_rdy, h0_resp); end
        step();
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1 || h0_resp !== 2'b01) begin errors++; $display("FAIL oob_err2: got rdy=%b resp=%b expected 1/01", h0_rdy, h0_resp); end
        step();
        @(negedge clk);
        checks++; if (h0_resp !== 2'b00 || h0_wrc !== 16'd2) begin errors++; $display("FAIL oob_after: got resp=%b wr=%0d expected 00/2", h0_resp, h0_wrc); end
        bus0(NONSEQ, 32'h0, 1'b0, 32'h0);
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdata !== 32'h12345678) begin errors++; $display("FAIL oob_mem_kept: got %h expected 12345678", h0_rdata); end
        step();
    endtask

    task automatic test_unaligned();
        bus0(NONSEQ, 32'h2, 1'b0, 32'h0);
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b0 || h0_resp !== 2'b01 || h0_rdata !== 32'h0) begin errors++; $display("FAIL unal_err1: got rdy=%b resp=%b rdata=%h expected 0/01/0", h0_rdy, h0_resp, h0_rdata); end
        step();
        bus0(NONSEQ, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1 || h0_resp !== 2'b01 || h0_rdata !== 32'h0) begin errors++; $display("FAIL unal_err2: got rdy=%b resp=%b rdata=%h expected 1/01/0", h0_rdy, h0_resp, h0_rdata); end
        step();
        bus0(IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1 || h0_resp !== 2'b00 || h0_rdata !== 32'h12345678) begin errors++; $display("FAIL unal_follow: got rdy=%b resp=%b rdata=%h expected 1/00/12345678", h0_rdy, h0_resp, h0_rdata); end
        step();
        @(negedge clk);
        checks++; if (h0_rdc !== 16'd3) begin errors++; $display("FAIL unal_rdcount: got %0d expected 3", h0_rdc); end
        step();
    endtask

    task automatic test_burst();
        burst_d[0] = 32'hA0A0_0001; burst_d[1] = 32'hB1B1_0002;
        burst_d[2] = 32'hC2C2_0003; burst_d[3] = 32'hD3D3_0004;
        bus0(NONSEQ, 32'h20, 1'b1, 32'h0);
        step();
        bus0(SEQ, 32'h24, 1'b1, burst_d[0]);
        step();
        bus0(BUSY, 32'h28, 1'b1, burst_d[1]);
        step();
        bus0(SEQ, 32'h28, 1'b1, 32'hBAD0BAD0);
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1 || h0_resp !== 2'b00) begin errors++; $display("FAIL burst_busy_okay: got rdy=%b resp=%b expected 1/00", h0_rdy, h0_resp); end
        step();
        bus0(SEQ, 32'h2C, 1'b1, burst_d[2]);
        step();
        bus0(IDLE, 32'h0, 1'b0, burst_d[3]);
        step();
        @(negedge clk);
        checks++; if (h0_wrc !== 16'd6) begin errors++; $display("FAIL burst_wrcount: got %0d expected 6", h0_wrc); end
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) bus0((i == 0) ? NONSEQ : SEQ, 32'h20 + 32'(i * 4), 1'b0, 32'h0);
            else       bus0(IDLE, 32'h0, 1'b0, 32'h0);
            if (i > 0) begin
                @(negedge clk);
                checks++; if (h0_rdata !== burst_d[i-1]) begin errors++; $display("FAIL burst_read%0d: got %h expected %h", i - 1, h0_rdata, burst_d[i-1]); end
            end
            step();
        end
        @(negedge clk);
        checks++; if (h0_rdc !== 16'd7) begin errors++; $display("FAIL burst_rdcount: got %0d expected 7", h0_rdc); end
        step();
    endtask

    task automatic test_wait_states();
        bus3(NONSEQ, 32'h4, 1'b1, 32'h0);
        step();
        bus3(IDLE, 32'h0, 1'b0, 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (h3_rdy !== 1'b0) begin errors++; $display("FAIL ws_write_wait%0d: got rdy=%b expected 0", k, h3_rdy); end
            step();
        end
        @(negedge clk);
        checks++; if (h3_rdy !== 1'b1) begin errors++; $display("FAIL ws_write_cmpl: got rdy=%b expected 1", h3_rdy); end
        step();
        bus3(NONSEQ, 32'h4, 1'b0, 32'h0);
        step();
        bus3(IDLE, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (h3_rdy !== 1'b0 || h3_resp !== 2'b00 || h3_rdata !== 32'h0) begin errors++; $display("FAIL ws_read_wait%0d: got rdy=%b resp=%b rdata=%h expected 0/00/0", k, h3_rdy, h3_resp, h3_rdata); end
            step();
        end
        @(negedge clk);
        checks++; if (h3_rdy !== 1'b1 || h3_resp !== 2'b00 || h3_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_read_cmpl: got rdy=%b resp=%b rdata=%h expected 1/00/cafef00d", h3_rdy, h3_resp, h3_rdata); end
        step();
        @(negedge clk);
        checks++; if (h3_rdc !== 16'd1 || h3_wrc !== 16'd1) begin errors++; $display("FAIL ws_counts: got rd=%0d wr=%0d expected 1/1", h3_rdc, h3_wrc); end
        step();
    endtask

    task automatic test_reset_mid();
        bus3(NONSEQ, 32'h4, 1'b1, 32'h0);
        step();
        bus3(IDLE, 32'h0, 1'b0, 32'h0BADBAD0);
        @(negedge clk);
        checks++; if (h3_state !== S_WAIT) begin errors++; $display("FAIL rstmid_pre_state: got %0d expected %0d", h3_state, S_WAIT); end
        #1 rst = 1'b1;
        #1;
        checks++; if (h3_rdy !== 1'b1 || h3_state !== S_IDLE) begin errors++; $display("FAIL rstmid_async: got rdy=%b state=%0d expected 1/0", h3_rdy, h3_state); end
        checks++; if (h3_rdc !== 16'd0 || h3_wrc !== 16'd0 || h0_wrc !== 16'd0) begin errors++; $display("FAIL rstmid_counts: got rd=%0d wr=%0d wr0=%0d expected 0/0/0", h3_rdc, h3_wrc, h0_wrc); end
        repeat (2) step();
        rst = 1'b0;
        step();
        bus3(NONSEQ, 32'h4, 1'b0, 32'h0);
        step();
        bus3(IDLE, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        @(negedge clk);
        checks++; if (h3_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_mem_kept: got %h expected cafef00d", h3_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_err_range();
        test_unaligned();
        test_burst();
        test_wait_states();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
